// File: rtl/vc_out_scheduler_pkg.sv
// vc_out_scheduler_pkg: flit-type constants, FSM state type and flit decode helper.
package vc_out_scheduler_pkg;
    localparam int FLIT_W_DEF = 34;
    localparam logic [1:0] HEAD_FLIT = 2'b00;
    localparam logic [1:0] BODY_FLIT = 2'b01;
    localparam logic [1:0] TAIL_FLIT = 2'b11;
    typedef enum logic {IDLE, LOCKED} state_t;
    // the reserved encoding travels as a BODY flit
    function automatic logic [1:0] flit_type(input logic [1:0] top);
        return top == 2'b10 ? BODY_FLIT : top;
    endfunction
endpackage

// File: rtl/vc_out_scheduler_if.sv
// vc_out_scheduler_if: per-VC flit inputs and the shared output link of the scheduler.
interface vc_out_scheduler_if import vc_out_scheduler_pkg::*; #(
    parameter int NUM_VC = 3,
    parameter int VC_W = 2,
    parameter int FLIT_W = FLIT_W_DEF
);
    logic [NUM_VC-1:0] vc_valid;
    logic [NUM_VC-1:0] vc_ready;
    logic [NUM_VC*FLIT_W-1:0] vc_fdata;
    logic [FLIT_W-1:0] fdata;
    logic [VC_W-1:0] vc_id;
    logic [VC_W-1:0] owner;
    logic valid;
    logic ready;
    logic locked;
    logic err;
    logic err_clr;
    modport master(output vc_valid, vc_fdata, ready, err_clr,
                   input vc_ready, fdata, vc_id, valid, locked, owner, err);
    modport slave(input vc_valid, vc_fdata, ready, err_clr,
                  output vc_ready, fdata, vc_id, valid, locked, owner, err);
endinterface

// File: rtl/vc_out_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx
);
    int j;
    // scan farthest-first so the request nearest ptr is the last to win
    always_comb begin
        grant = '0;
        idx = '0;
        j = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k >= N ? int'(ptr) + k - N : int'(ptr) + k;
            if (req[j]) begin
                grant = '0;
                grant[j] = 1'b1;
                idx = W'(j);
            end
        end
    end
endmodule

// File: rtl/vc_out_scheduler.sv
// vc_out_scheduler: round-robin, packet-locked sharing of one output link among VC buffers.
module vc_out_scheduler import vc_out_scheduler_pkg::*; #(
    parameter int NUM_VC = 3,
    parameter int VC_W = 2,
    parameter int FLIT_W = FLIT_W_DEF
) (
    input logic clk,
    input logic arst,
    vc_out_scheduler_if.slave bus
);
    state_t state;
    logic [VC_W-1:0] rr_ptr;
    logic [VC_W-1:0] gidx;
    logic [NUM_VC-1:0] req;
    logic [NUM_VC-1:0] bad;
    logic [NUM_VC-1:0] grant;
    logic [1:0] ftype;
    logic own;
    logic accept;
    logic xfer;
    logic [FLIT_W-1:0] gflit;
    always_comb begin
        req = '0;
        bad = '0;
        ftype = '0;
        own = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            ftype = flit_type(bus.vc_fdata[i*FLIT_W+FLIT_W-2 +: 2]);
            own = state == LOCKED && VC_W'(i) == bus.owner;
            req[i] = bus.vc_valid[i] & (state == IDLE ? ftype == HEAD_FLIT : own && ftype != HEAD_FLIT);
            bad[i] = bus.vc_valid[i] & (state == IDLE ? ftype != HEAD_FLIT : own && ftype == HEAD_FLIT);
        end
    end
    rr_arbiter #(.N(NUM_VC), .W(VC_W)) u_arb (
        .req(req),
        .ptr(rr_ptr),
        .grant(grant),
        .idx(gidx)
    );
    assign accept = !bus.valid | bus.ready;
    assign bus.vc_ready = (accept & arst) ? grant : '0;
    assign xfer = |bus.vc_ready;
    assign gflit = bus.vc_fdata[gidx*FLIT_W +: FLIT_W];
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state <= IDLE;
            rr_ptr <= '0;
            bus.valid <= 1'b0;
            bus.fdata <= '0;
            bus.vc_id <= '0;
            bus.locked <= 1'b0;
            bus.owner <= '0;
            bus.err <= 1'b0;
        end else begin
            if (accept) bus.valid <= xfer;
            if (xfer) begin
                bus.fdata <= gflit;
                bus.vc_id <= gidx;
            end
            bus.err <= |bad | (bus.err & !bus.err_clr);
            if (xfer && state == IDLE) begin
                state <= LOCKED;
                bus.locked <= 1'b1;
                bus.owner <= gidx;
            end else if (xfer && flit_type(gflit[FLIT_W-1 -: 2]) == TAIL_FLIT) begin
                state <= IDLE;
                bus.locked <= 1'b0;
                rr_ptr <= bus.owner == VC_W'(NUM_VC - 1) ? '0 : bus.owner + VC_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_vc_out_scheduler.sv
// tb_vc_out_scheduler: directed checks of arbitration, locking, backpressure, errors and reset.
module tb_vc_out_scheduler;
    localparam int NV = 3;
    localparam int VW = 2;
    localparam int FW = 34;
    localparam logic [1:0] H = 2'b00, B = 2'b01, R = 2'b10, T = 2'b11;
    logic clk = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;
    vc_out_scheduler_if #(.NUM_VC(NV), .VC_W(VW), .FLIT_W(FW)) bus ();
    vc_out_scheduler #(.NUM_VC(NV), .VC_W(VW), .FLIT_W(FW)) dut (.clk(clk), .arst(arst), .bus(bus));
    int tests = 0;
    int fails = 0;
    logic [FW-1:0] q[NV][$];
    logic [NV-1:0] rdy;
    logic [FW-1:0] dummy;
    int exp_ids[8] = '{0, 0, 1, 1, 2, 2, 0, 0};
    int n;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [FW-1:0] fl(input logic [1:0] t, input logic [31:0] p);
        return {t, p};
    endfunction
    task automatic drive();
        for (int i = 0; i < NV; i++) begin
            bus.vc_valid[i] = q[i].size() != 0;
            bus.vc_fdata[i*FW +: FW] = q[i].size() != 0 ? q[i][0] : '0;
        end
    endtask
    // one clock: present queue heads, record the pop strobes, pop what transferred
    task automatic cyc();
        drive();
        #1 rdy = bus.vc_ready;
        @(posedge clk);
        for (int i = 0; i < NV; i++) if (rdy[i]) dummy = q[i].pop_front();
        #1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        bus.ready = 1'b1;
        bus.err_clr = 1'b0;
        q[0].push_back(fl(H, 32'h1));
        drive();
        #1 arst = 1'b0;
        #1;
        check("rst_valid", bus.valid, 0);
        check("rst_fdata", bus.fdata, 0);
        check("rst_vcid", bus.vc_id, 0);
        check("rst_locked", bus.locked, 0);
        check("rst_owner", bus.owner, 0);
        check("rst_err", bus.err, 0);
        check("rst_vc_ready", bus.vc_ready, 0);
        q[0].delete();
        drive();
        repeat (2) @(posedge clk);
        #1 arst = 1'b1;
        // round robin over three VCs, VC0 with two packets
        q[0] = '{fl(H, 32'h10), fl(T, 32'h11), fl(H, 32'h12), fl(T, 32'h13)};
        q[1] = '{fl(H, 32'h20), fl(T, 32'h21)};
        q[2] = '{fl(H, 32'h30), fl(T, 32'h31)};
        n = 0;
        repeat (10) begin
            cyc();
            check("rr_onehot", 64'($onehot0(rdy)), 1);
            if (bus.valid && n < 8) begin
                check($sformatf("rr_id%0d", n), bus.vc_id, exp_ids[n]);
                n++;
            end
        end
        check("rr_count", n, 8);
        // protocol error in IDLE (rr_ptr=1)
        q[1].push_back(fl(B, 32'h40));
        cyc();
        check("perr_rdy", rdy, 0);
        check("perr_set", bus.err, 1);
        cyc();
        check("perr_nopop", q[1].size(), 1);
        q[1].delete();
        bus.err_clr = 1'b1;
        cyc();
        bus.err_clr = 1'b0;
        check("perr_clr", bus.err, 0);
        q[0].push_back(fl(H, 32'h50));
        cyc();
        check("perr_locked", bus.locked, 1);
        check("perr_owner", bus.owner, 0);
        q[0].push_back(fl(H, 32'h51));
        bus.err_clr = 1'b1;
        cyc();
        bus.err_clr = 1'b0;
        check("perr_head_rdy", rdy, 0);
        check("perr_prio", bus.err, 1);
        q[0].delete();
        q[0].push_back(fl(T, 32'h52));
        cyc();
        check("perr_tail_rdy", rdy, 3'b001);
        check("perr_unlock", bus.locked, 0);
        bus.err_clr = 1'b1;
        cyc();
        bus.err_clr = 1'b0;
        check("perr_clr2", bus.err, 0);
        // wrap: move rr_ptr to 2, then VC0 and VC1 both request
        q[1] = '{fl(H, 32'h60), fl(T, 32'h61)};
        repeat (2) cyc();
        q[0] = '{fl(H, 32'h70), fl(T, 32'h71)};
        q[1] = '{fl(H, 32'h80), fl(T, 32'h81)};
        cyc();
        check("wrap_first", rdy, 3'b001);
        check("wrap_owner", bus.owner, 0);
        cyc();
        cyc();
        check("wrap_second", rdy, 3'b010);
        cyc();
        q[2] = '{fl(H, 32'h90), fl(T, 32'h91)};
        repeat (2) cyc();
        // locking: VC2 HEAD waits while VC0 packet runs (rr_ptr=0)
        q[0] = '{fl(H, 32'hA0), fl(B, 32'hA1), fl(R, 32'hA2), fl(T, 32'hA3)};
        q[2] = '{fl(H, 32'hB0), fl(T, 32'hB1)};
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("lock_rdy%0d", k), rdy, 3'b001);
        end
        cyc();
        check("lock_vc2_grant", rdy, 3'b100);
        check("lock_owner2", bus.owner, 2);
        check("lock_locked", bus.locked, 1);
        cyc();
        repeat (2) cyc();
        check("bp_idle", bus.valid, 0);
        // backpressure
        bus.ready = 1'b0;
        q[0] = '{fl(H, 32'h1234), fl(T, 32'h5678)};
        cyc();
        check("bp_load_rdy", rdy, 3'b001);
        check("bp_load", bus.fdata, 34'h0_0000_1234);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("bp_rdy%0d", k), rdy, 0);
            check($sformatf("bp_hold%0d", k), bus.fdata, 34'h0_0000_1234);
            check($sformatf("bp_valid%0d", k), bus.valid, 1);
        end
        bus.ready = 1'b1;
        cyc();
        check("bp_release_rdy", rdy, 3'b001);
        check("bp_release_data", bus.fdata, {T, 32'h5678});
        cyc();
        check("bp_one_only", rdy, 0);
        // reset in the middle of a VC1 packet
        q[1] = '{fl(H, 32'hC0), fl(B, 32'hC1)};
        repeat (2) cyc();
        check("mid_locked", bus.locked, 1);
        check("mid_owner", bus.owner, 1);
        q[1].push_back(fl(B, 32'hC2));
        drive();
        arst = 1'b0;
        #1;
        check("mid_rst_valid", bus.valid, 0);
        check("mid_rst_locked", bus.locked, 0);
        check("mid_rst_err", bus.err, 0);
        check("mid_rst_rdy", bus.vc_ready, 0);
        @(posedge clk);
        #1 arst = 1'b1;
        cyc();
        check("mid_body_rdy", rdy, 0);
        check("mid_err", bus.err, 1);
        check("mid_valid", bus.valid, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
